fetch_unit: RTL and testbench

- Instruction-fetch stage between the program counter register and the decode stage.
- Computes the PC register's next value: sequential +4, or a redirect target from EX.
- Drives the PC register's stall input.
- Captures the fetched instruction and its PC into the IF/ID pipeline register, with stall, flush-bubble and valid tracking.
- 8-bit byte addresses, 32-bit instructions; instruction memory is combinational-read and external.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, PC-register stall, and the IF/ID register with flush bubbles.
// Build option: define FETCH_PERF_EN to add saturating fetch/bubble counters (perf_fetched, perf_bubbles).
module fetch_unit #(
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [7:0]  pc_cur,
    input  logic [31:0] instr_in,
    input  logic        redirect_en,
    input  logic [7:0]  redirect_target,
    output logic [7:0]  pc_next,
    output logic        pc_stall,
    output logic        if_valid,
    output logic [7:0]  if_pc,
    output logic [7:0]  if_pc_plus4,
`ifdef FETCH_PERF_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_bubbles,
`endif
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_FETCH
    } act_e;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [7:0]  w_pc_plus4;
    logic        w_flushing;
    act_e        w_act;

    logic        r_if_valid;
    logic [7:0]  r_if_pc;
    logic [7:0]  r_if_pc_plus4;
    logic [31:0] r_if_instr;
    logic [2:0]  r_flush_cnt;

    assign w_pc_plus4 = pc_cur + 8'd4;
    assign w_flushing = (r_flush_cnt != 3'd0);

    always_comb begin
        pc_next = w_pc_plus4;
        if (redirect_en) begin
            pc_next = {redirect_target[7:2], 2'b00};
        end
    end

    // A redirect always lets the PC register take its target, even over a stall or an active flush.
    assign pc_stall = ~redirect_en & (stall | w_flushing);

    always_comb begin
        w_act = ACT_FETCH;
        if (redirect_en) begin
            w_act = ACT_REDIRECT;
        end else if (w_flushing) begin
            w_act = ACT_FLUSH;
        end else if (stall) begin
            w_act = ACT_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid    <= 1'b0;
            r_if_pc       <= 8'h00;
            r_if_pc_plus4 <= 8'h04;
            r_if_instr    <= NOP_INSTR;
            r_flush_cnt   <= 3'd0;
        end else begin
            case (w_act)
                ACT_REDIRECT: begin
                    r_if_valid    <= 1'b0;
                    r_if_instr    <= NOP_INSTR;
                    r_if_pc       <= pc_cur;
                    r_if_pc_plus4 <= w_pc_plus4;
                    r_flush_cnt   <= FLUSH_RELOAD;
                end
                ACT_FLUSH: begin
                    r_if_valid    <= 1'b0;
                    r_if_instr    <= NOP_INSTR;
                    r_if_pc       <= pc_cur;
                    r_if_pc_plus4 <= w_pc_plus4;
                    r_flush_cnt   <= r_flush_cnt - 3'd1;
                end
                ACT_HOLD: begin
                    r_flush_cnt   <= r_flush_cnt;
                end
                default: begin
                    r_if_valid    <= 1'b1;
                    r_if_instr    <= instr_in;
                    r_if_pc       <= pc_cur;
                    r_if_pc_plus4 <= w_pc_plus4;
                end
            endcase
        end
    end

    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;

`ifdef FETCH_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 16'h0000;
            r_perf_bubbles <= 16'h0000;
        end else begin
            if (w_act == ACT_FETCH) begin
                r_perf_fetched <= sat_inc16(r_perf_fetched);
            end
            if ((w_act == ACT_REDIRECT) || (w_act == ACT_FLUSH)) begin
                r_perf_bubbles <= sat_inc16(r_perf_bubbles);
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (FLUSH_CYCLES 1, 3, 2) share stimulus, each with its own PC register.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_en;
    logic [7:0]  redirect_target;

    logic [7:0]  pc_cur      [3];
    logic [7:0]  pc_next     [3];
    logic        pc_stall    [3];
    logic        if_valid    [3];
    logic [7:0]  if_pc       [3];
    logic [7:0]  if_pc_plus4 [3];
    logic [31:0] if_instr    [3];
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched [3];
    logic [15:0] perf_bubbles [3];
`endif

    logic [31:0] imem [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External PC register, one per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) pc_cur[k] <= 8'h00;
            else if (!pc_stall[k]) pc_cur[k] <= pc_next[k];
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            fetch_unit #(
                .FLUSH_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
                .NOP_INSTR   (NOP)
            ) u_dut (
                .clk            (clk),
                .reset          (reset),
                .stall          (stall),
                .pc_cur         (pc_cur[g]),
                .instr_in       (imem[pc_cur[g][7:2]]),
                .redirect_en    (redirect_en),
                .redirect_target(redirect_target),
                .pc_next        (pc_next[g]),
                .pc_stall       (pc_stall[g]),
                .if_valid       (if_valid[g]),
                .if_pc          (if_pc[g]),
                .if_pc_plus4    (if_pc_plus4[g]),
`ifdef FETCH_PERF_EN
                .perf_fetched   (perf_fetched[g]),
                .perf_bubbles   (perf_bubbles[g]),
`endif
                .if_instr       (if_instr[g])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = 8'h00;
        repeat (2) tick();
        n_checks++; if (if_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid[0]); end
        n_checks++; if (if_pc[0] !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h want 00", if_pc[0]); end
        n_checks++; if (if_pc_plus4[0] !== 8'h04) begin n_fail++; $display("FAIL rst_pc4: got %h want 04", if_pc_plus4[0]); end
        n_checks++; if (if_instr[0] !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", if_instr[0], NOP); end
        n_checks++; if (pc_next[0] !== 8'h04) begin n_fail++; $display("FAIL rst_pc_next: got %h want 04", pc_next[0]); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        tick();
        n_checks++; if (if_valid[0] !== 1'b1) begin n_fail++; $display("FAIL seq0_valid: got %b want 1", if_valid[0]); end
        n_checks++; if (if_pc[0] !== 8'h00) begin n_fail++; $display("FAIL seq0_pc: got %h want 00", if_pc[0]); end
        n_checks++; if (if_instr[0] !== 32'h0050_0093) begin n_fail++; $display("FAIL seq0_instr: got %h want 00500093", if_instr[0]); end
        n_checks++; if (pc_next[0] !== 8'h08) begin n_fail++; $display("FAIL seq0_pc_next: got %h want 08", pc_next[0]); end
        tick();
        n_checks++; if (if_pc[0] !== 8'h04) begin n_fail++; $display("FAIL seq1_pc: got %h want 04", if_pc[0]); end
        n_checks++; if (if_pc_plus4[0] !== 8'h08) begin n_fail++; $display("FAIL seq1_pc4: got %h want 08", if_pc_plus4[0]); end
        n_checks++; if (if_instr[0] !== 32'h0010_0113) begin n_fail++; $display("FAIL seq1_instr: got %h want 00100113", if_instr[0]); end
        n_checks++; if (pc_cur[0] !== 8'h08) begin n_fail++; $display("FAIL seq1_pc_cur: got %h want 08", pc_cur[0]); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        n_checks++; if (pc_stall[0] !== 1'b1) begin n_fail++; $display("FAIL stall_pc_stall: got %b want 1", pc_stall[0]); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (if_pc[0] !== 8'h04) begin n_fail++; $display("FAIL stall_hold_pc[%0d]: got %h want 04", i, if_pc[0]); end
            n_checks++; if (if_instr[0] !== 32'h0010_0113) begin n_fail++; $display("FAIL stall_hold_instr[%0d]: got %h want 00100113", i, if_instr[0]); end
            n_checks++; if (pc_cur[0] !== 8'h08) begin n_fail++; $display("FAIL stall_pc_cur[%0d]: got %h want 08", i, pc_cur[0]); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (if_pc[0] !== 8'h08) begin n_fail++; $display("FAIL stall_rel_pc: got %h want 08", if_pc[0]); end
        n_checks++; if (if_instr[0] !== 32'h0020_81B3) begin n_fail++; $display("FAIL stall_rel_instr: got %h want 002081b3", if_instr[0]); end
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1; redirect_target = 8'h43; stall = 1'b1;
        #1;
        n_checks++; if (pc_next[0] !== 8'h40) begin n_fail++; $display("FAIL redir_pc_next: got %h want 40", pc_next[0]); end
        n_checks++; if (pc_stall[0] !== 1'b0) begin n_fail++; $display("FAIL redir_pc_stall: got %b want 0", pc_stall[0]); end
        tick();
        redirect_en = 1'b0; stall = 1'b0;
        n_checks++; if (if_valid[0] !== 1'b0) begin n_fail++; $display("FAIL redir_bub_valid: got %b want 0", if_valid[0]); end
        n_checks++; if (if_instr[0] !== NOP) begin n_fail++; $display("FAIL redir_bub_instr: got %h want %h", if_instr[0], NOP); end
        n_checks++; if (pc_cur[0] !== 8'h40) begin n_fail++; $display("FAIL redir_pc_cur: got %h want 40", pc_cur[0]); end
        tick();
        n_checks++; if (if_valid[0] !== 1'b1) begin n_fail++; $display("FAIL redir_res_valid: got %b want 1", if_valid[0]); end
        n_checks++; if (if_pc[0] !== 8'h40) begin n_fail++; $display("FAIL redir_res_pc: got %h want 40", if_pc[0]); end
        n_checks++; if (if_instr[0] !== 32'hA000_0010) begin n_fail++; $display("FAIL redir_res_instr: got %h want a0000010", if_instr[0]); end
        n_checks++; if (if_pc_plus4[0] !== 8'h44) begin n_fail++; $display("FAIL redir_res_pc4: got %h want 44", if_pc_plus4[0]); end
    endtask

    task automatic test_flush();
        do_reset();
        redirect_en = 1'b1; redirect_target = 8'h20;
        #1;
        n_checks++; if (pc_next[1] !== 8'h20) begin n_fail++; $display("FAIL fl_pc_next: got %h want 20", pc_next[1]); end
        tick();
        redirect_en = 1'b0; stall = 1'b1;
        #1;
        n_checks++; if (pc_stall[1] !== 1'b1) begin n_fail++; $display("FAIL fl_pc_stall: got %b want 1", pc_stall[1]); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (if_valid[1] !== 1'b0) begin n_fail++; $display("FAIL fl_bub_valid[%0d]: got %b want 0", i, if_valid[1]); end
            n_checks++; if (if_instr[1] !== NOP) begin n_fail++; $display("FAIL fl_bub_instr[%0d]: got %h want %h", i, if_instr[1], NOP); end
            n_checks++; if (pc_cur[1] !== 8'h20) begin n_fail++; $display("FAIL fl_pc_hold[%0d]: got %h want 20", i, pc_cur[1]); end
            if (i == 2) stall = 1'b0;
            tick();
        end
        n_checks++; if (if_valid[1] !== 1'b1) begin n_fail++; $display("FAIL fl_res_valid: got %b want 1", if_valid[1]); end
        n_checks++; if (if_pc[1] !== 8'h20) begin n_fail++; $display("FAIL fl_res_pc: got %h want 20", if_pc[1]); end
        n_checks++; if (if_instr[1] !== 32'hA000_0008) begin n_fail++; $display("FAIL fl_res_instr: got %h want a0000008", if_instr[1]); end

        // Restart: second redirect arrives after the second bubble edge.
        redirect_en = 1'b1; redirect_target = 8'h20;
        tick();
        redirect_en = 1'b0;
        tick();
        redirect_en = 1'b1; redirect_target = 8'h80;
        #1;
        n_checks++; if (pc_next[1] !== 8'h80) begin n_fail++; $display("FAIL rs_pc_next: got %h want 80", pc_next[1]); end
        n_checks++; if (pc_stall[1] !== 1'b0) begin n_fail++; $display("FAIL rs_pc_stall: got %b want 0", pc_stall[1]); end
        tick();
        redirect_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (if_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rs_bub_valid[%0d]: got %b want 0", i, if_valid[1]); end
            n_checks++; if (pc_cur[1] !== 8'h80) begin n_fail++; $display("FAIL rs_pc_hold[%0d]: got %h want 80", i, pc_cur[1]); end
            tick();
        end
        n_checks++; if (if_valid[1] !== 1'b1) begin n_fail++; $display("FAIL rs_res_valid: got %b want 1", if_valid[1]); end
        n_checks++; if (if_pc[1] !== 8'h80) begin n_fail++; $display("FAIL rs_res_pc: got %h want 80", if_pc[1]); end
        n_checks++; if (if_instr[1] !== 32'hA000_0020) begin n_fail++; $display("FAIL rs_res_instr: got %h want a0000020", if_instr[1]); end
    endtask

    task automatic test_reset_mid_flush();
        redirect_en = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (pc_cur[1] !== 8'h00) begin n_fail++; $display("FAIL rmf_pc_cur: got %h want 00", pc_cur[1]); end
        tick();
        n_checks++; if (if_valid[1] !== 1'b1) begin n_fail++; $display("FAIL rmf_valid: got %b want 1", if_valid[1]); end
        n_checks++; if (if_pc[1] !== 8'h00) begin n_fail++; $display("FAIL rmf_pc: got %h want 00", if_pc[1]); end
        n_checks++; if (if_instr[1] !== 32'h0050_0093) begin n_fail++; $display("FAIL rmf_instr: got %h want 00500093", if_instr[1]); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_en = 1'b1; redirect_target = 8'hFC;
        tick();
        redirect_en = 1'b0;
        #1;
        n_checks++; if (pc_cur[0] !== 8'hFC) begin n_fail++; $display("FAIL wrap_pc_cur: got %h want fc", pc_cur[0]); end
        n_checks++; if (pc_next[0] !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_next: got %h want 00", pc_next[0]); end
        tick();
        n_checks++; if (if_pc[0] !== 8'hFC) begin n_fail++; $display("FAIL wrap_if_pc: got %h want fc", if_pc[0]); end
        n_checks++; if (if_pc_plus4[0] !== 8'h00) begin n_fail++; $display("FAIL wrap_pc4: got %h want 00", if_pc_plus4[0]); end
        n_checks++; if (if_instr[0] !== 32'hA000_003F) begin n_fail++; $display("FAIL wrap_instr: got %h want a000003f", if_instr[0]); end
        n_checks++; if (pc_next[0] !== 8'h04) begin n_fail++; $display("FAIL wrap_pc_next2: got %h want 04", pc_next[0]); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        n_checks++; if (perf_fetched[2] !== 16'd0) begin n_fail++; $display("FAIL perf_rst_f: got %0d want 0", perf_fetched[2]); end
        n_checks++; if (perf_bubbles[2] !== 16'd0) begin n_fail++; $display("FAIL perf_rst_b: got %0d want 0", perf_bubbles[2]); end
        repeat (10) tick();
        redirect_en = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_en = 1'b0;
        tick();
        n_checks++; if (perf_fetched[2] !== 16'd10) begin n_fail++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched[2]); end
        n_checks++; if (perf_bubbles[2] !== 16'd2) begin n_fail++; $display("FAIL perf_bubbles: got %0d want 2", perf_bubbles[2]); end
        force g_dut[2].u_dut.r_perf_fetched = 16'hFFFF;
        #1;
        release g_dut[2].u_dut.r_perf_fetched;
        repeat (3) tick();
        n_checks++; if (perf_fetched[2] !== 16'hFFFF) begin n_fail++; $display("FAIL perf_sat: got %h want ffff", perf_fetched[2]); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = 8'h00;
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + 32'(i);
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0010_0113;
        imem[2] = 32'h0020_81B3;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_mid_flush();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
